timer_device: RTL

TIMER_DEVICE -- requirements
Module: timer_device

---
 rtl/timer_device.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/timer_device.sv
`default_nettype none
// ============================================================================
//  Module   : timer_device
//  Purpose  : Bus-mapped countdown timer (CTRL / PRESET / COUNT registers)
//             with one-shot and auto-reload modes and a maskable interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module timer_device (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:2] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] ADDR_CTRL   = 2'b00;
    localparam logic [1:0] ADDR_PRESET = 2'b01;
    localparam logic [1:0] ADDR_COUNT  = 2'b10;

    localparam logic [1:0] MODE_AUTO   = 2'b01;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LOAD     = 2'd1;
    localparam logic [1:0] ST_CNT      = 2'd2;
    localparam logic [1:0] ST_INT      = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic        irqf_q, irqf_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;

    logic        wr_any, wr_ctrl, wr_preset;
    logic        fsm_load, fsm_dec, fsm_zero, fsm_set_irqf, fsm_clr_irqf, fsm_clr_en;

    // Only addr[3:2] selects a register; upper word-address bits are don't-care.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^addr[31:4];

    // Any nonzero byte enable on a selected access is a write.
    assign wr_any    = sel && (byteen != 4'b0000);
    assign wr_ctrl   = wr_any && (addr[3:2] == ADDR_CTRL);
    assign wr_preset = wr_any && (addr[3:2] == ADDR_PRESET);

    // State register: asynchronous abort to IDLE on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the FSM reacts to the registered EN bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = en_q ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_d = ST_CNT;
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    state_d = ST_CNT;
                end else begin
                    state_d = ST_INT;
                end
            end
            ST_INT:  state_d = (mode_q == MODE_AUTO) ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output actions on the datapath registers.
    always_comb begin
        fsm_load     = 1'b0;
        fsm_dec      = 1'b0;
        fsm_zero     = 1'b0;
        fsm_set_irqf = 1'b0;
        fsm_clr_irqf = 1'b0;
        fsm_clr_en   = 1'b0;
        case (state_q)
            ST_LOAD: fsm_load = 1'b1;
            ST_CNT: begin
                if (en_q) begin
                    if (count_q > 32'd1) begin
                        fsm_dec = 1'b1;
                    end else begin
                        fsm_zero     = 1'b1;
                        fsm_set_irqf = 1'b1;
                    end
                end
            end
            ST_INT: begin
                if (mode_q == MODE_AUTO) begin
                    fsm_clr_irqf = 1'b1;
                end else begin
                    fsm_clr_en   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Register next values: CPU writes are applied after FSM actions so they win.
    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        irqf_d   = irqf_q;
        preset_d = preset_q;
        count_d  = count_q;

        if (fsm_clr_en) begin
            en_d = 1'b0;
        end
        if (wr_ctrl && byteen[0]) begin
            en_d   = wdata[0];
            mode_d = wdata[2:1];
            im_d   = wdata[3];
        end

        if (wr_preset) begin
            for (int i = 0; i < 4; i++) begin
                if (byteen[i]) begin
                    preset_d[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end

        // Decrement only happens when COUNT > 1, so it never wraps.
        if (fsm_load) begin
            count_d = preset_q;
        end else if (fsm_dec) begin
            count_d = count_q - 32'd1;
        end else if (fsm_zero) begin
            count_d = 32'd0;
        end

        if (fsm_set_irqf) begin
            irqf_d = 1'b1;
        end
        if (fsm_clr_irqf || wr_ctrl || wr_preset) begin
            irqf_d = 1'b0;
        end
    end

    // Datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            irqf_q   <= 1'b0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            irqf_q   <= irqf_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

    // Combinational read mux; zero when the device is not selected.
    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr[3:2])
                ADDR_CTRL:   rdata = {27'd0, irqf_q, im_q, mode_q, en_q};
                ADDR_PRESET: rdata = preset_q;
                ADDR_COUNT:  rdata = count_q;
                default:     rdata = 32'd0;
            endcase
        end
    end

    assign irq = irqf_q & im_q;

endmodule
`default_nettype wire
